// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
// Shared definitions for the 65C02 bus cycle sequencer:
//   - bus_state_t : sequencer states
//   - Q_LAUNCH    : phase step on which bus cycles launch and complete
//   - Q_DRIVE     : phase step on which write data starts driving the bus
//   - default address / data / wait-counter widths
package cpu_bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int WAIT_W_DEF = 8;

    // q value seen on the boundary edge (end of phi2)
    localparam logic [1:0] Q_LAUNCH = 2'b11;
    // q value on the edge just before phi2 rises
    localparam logic [1:0] Q_DRIVE  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10
    } bus_state_t;

endpackage : cpu_bus_pkg

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer
// Runs 65C02 external bus cycles paced by the q/p phase outputs of the
// timing generator. A bus cycle is four fclk long. It launches on the edge
// where q==3 and completes on the next q==3 edge. RDY low on that edge
// stretches it by another four fclk.
// Ports:
//   fclk, resb                       clock, async active-low reset
//   q, p                             phase step and phi2 level from the timing generator
//   req, req_we, req_addr,
//   req_wdata, req_sync              core access request, held until ack
//   ack, rvalid, rdata               request consumed / read data strobe and data
//   a, rwb, sync, d_out, d_oe        bus pins toward the outside world
//   rdy, d_in                        RDY pin and data bus input
//   busy, wait_cnt, phase_err        status: cycle running, wait states, phase fault
module bus_cycle_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WAIT_W = WAIT_W_DEF
) (
    input  logic              fclk,
    input  logic              resb,
    input  logic [1:0]        q,
    input  logic              p,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_sync,
    output logic              ack,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] a,
    output logic              rwb,
    output logic              sync,
    output logic [DATA_W-1:0] d_out,
    output logic              d_oe,
    input  logic              rdy,
    input  logic [DATA_W-1:0] d_in,
    output logic              busy,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              phase_err
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

    bus_state_t        state_r;
    logic              ack_r;
    logic              rvalid_r;
    logic [DATA_W-1:0] rdata_r;
    logic [ADDR_W-1:0] a_r;
    logic              rwb_r;
    logic              sync_r;
    logic [DATA_W-1:0] d_out_r;
    logic              d_oe_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              phase_err_r;

    logic boundary_s;
    logic drive_s;
    logic launch_s;

    // Phase decode and launch condition: a new access is taken on a boundary
    // edge either from idle or on the same edge the current access completes.
    always_comb begin
        boundary_s = (q == Q_LAUNCH);
        drive_s    = (q == Q_DRIVE);
        launch_s   = boundary_s && req && ((state_r == ST_IDLE) || rdy);
    end

    // Bus cycle state machine with all bus and handshake outputs registered.
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            state_r     <= ST_IDLE;
            ack_r       <= 1'b0;
            rvalid_r    <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
            a_r         <= {ADDR_W{1'b0}};
            rwb_r       <= 1'b1;
            sync_r      <= 1'b0;
            d_out_r     <= {DATA_W{1'b0}};
            d_oe_r      <= 1'b0;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            phase_err_r <= 1'b0;
        end else begin
            ack_r    <= 1'b0;
            rvalid_r <= 1'b0;

            // phi2 must be high exactly on the upper two phase steps
            if (p != q[1]) begin
                phase_err_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (boundary_s && !req) begin
                        rwb_r  <= 1'b1;
                        sync_r <= 1'b0;
                    end
                end
                ST_ACTIVE, ST_STALL: begin
                    // Only the first (unstretched) bus cycle raises d_oe;
                    // during a stall it is simply held.
                    if ((state_r == ST_ACTIVE) && drive_s && !rwb_r) begin
                        d_oe_r <= 1'b1;
                    end
                    if (boundary_s) begin
                        if (rdy) begin
                            if (rwb_r) begin
                                rdata_r  <= d_in;
                                rvalid_r <= 1'b1;
                            end
                            d_oe_r <= 1'b0;
                            if (!req) begin
                                state_r <= ST_IDLE;
                                rwb_r   <= 1'b1;
                                sync_r  <= 1'b0;
                            end
                        end else begin
                            state_r <= ST_STALL;
                            if (wait_cnt_r != WAIT_MAX) begin
                                wait_cnt_r <= wait_cnt_r + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // Launch overrides the completion defaults above so that a
            // back-to-back access begins on the completing edge.
            if (launch_s) begin
                a_r        <= req_addr;
                rwb_r      <= ~req_we;
                sync_r     <= req_sync;
                d_out_r    <= req_wdata;
                ack_r      <= 1'b1;
                wait_cnt_r <= {WAIT_W{1'b0}};
                state_r    <= ST_ACTIVE;
            end
        end
    end

    assign ack       = ack_r;
    assign rvalid    = rvalid_r;
    assign rdata     = rdata_r;
    assign a         = a_r;
    assign rwb       = rwb_r;
    assign sync      = sync_r;
    assign d_out     = d_out_r;
    assign d_oe      = d_oe_r;
    assign busy      = (state_r != ST_IDLE);
    assign wait_cnt  = wait_cnt_r;
    assign phase_err = phase_err_r;

endmodule : bus_cycle_sequencer

// File: tb/tb_bus_cycle_sequencer.sv
// tb_bus_cycle_sequencer
// Scoreboard bench for bus_cycle_sequencer. A timing-generator model drives
// q/p, a memory device answers bus cycles, the stimulus process pushes the
// expected accept/read results into queues and a monitor pops and compares.
// Per fclk period: q/p update at +1, device at +2, stimulus at +3, monitor at +4.
module tb_bus_cycle_sequencer;
    import cpu_bus_pkg::*;

    logic        fclk = 1'b0;
    logic        resb = 1'b0;
    logic [1:0]  q = 2'd0;
    logic        p = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        req_sync = 1'b0;
    logic        rdy = 1'b1;
    logic [7:0]  d_in = 8'h00;
    logic        ack, rvalid, rwb, sync, d_oe, busy, phase_err;
    logic [7:0]  rdata, d_out, wait_cnt;
    logic [15:0] a;

    bus_cycle_sequencer #(.ADDR_W(16), .DATA_W(8), .WAIT_W(8)) dut (
        .fclk(fclk), .resb(resb), .q(q), .p(p),
        .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_sync(req_sync),
        .ack(ack), .rvalid(rvalid), .rdata(rdata),
        .a(a), .rwb(rwb), .sync(sync), .d_out(d_out), .d_oe(d_oe),
        .rdy(rdy), .d_in(d_in), .busy(busy), .wait_cnt(wait_cnt),
        .phase_err(phase_err)
    );

    always #5 fclk = ~fclk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        sync;
    } acc_t;

    int   checks = 0;
    int   failures = 0;
    acc_t exp_acc[$];
    logic [7:0] exp_rd[$];
    logic [7:0] ref_mem [65536];
    logic [7:0] dev_mem [65536];
    int   stall_plan = 0;
    bit   rand_rdy = 1'b0;
    bit   p_flip = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // Timing generator model: q steps every fclk, p is phi2 (optionally corrupted).
    initial begin
        forever begin
            @(posedge fclk);
            #1;
            q = q + 2'd1;
            p = q[1] ^ p_flip;
        end
    end

    // Memory device on the bus; rdy/d_in matter only before boundary edges,
    // so other periods get random junk.
    int stall_cnt = 0;
    int stall_rem = 0;
    initial begin
        forever begin
            @(posedge fclk);
            #2;
            if (!resb) begin
                stall_cnt = 0;
                stall_rem = 0;
            end else if (ack) begin
                stall_cnt = 0;
                stall_rem = stall_plan;
            end
            if (q == 2'd3) begin
                d_in = dev_mem[a];
                if (stall_rem > 0) rdy = 1'b0;
                else if (rand_rdy) rdy = ($urandom_range(0, 2) != 0);
                else rdy = 1'b1;
                if (busy && resb) begin
                    if (!rdy) begin
                        if (stall_cnt < 255) stall_cnt++;
                        if (stall_rem > 0) stall_rem--;
                    end else if (!rwb) begin
                        dev_mem[a] = d_out;
                    end
                end
            end else begin
                d_in = 8'($urandom);
                rdy  = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops expectations on ack/rvalid, checks bus holding every cycle.
    acc_t       cur = '0;
    logic [7:0] e_rd;
    logic       exp_oe;
    initial begin
        forever begin
            @(posedge fclk);
            #4;
            if (!resb) begin
                cur = '0;
                chk("reset_outputs",
                    {a, rwb, sync, d_out, d_oe, ack, rvalid, rdata, wait_cnt, busy, phase_err},
                    {16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
            end else begin
                if (rvalid) begin
                    chk("rvalid_phase", q, 2'd0);
                    if (exp_rd.size() == 0) begin
                        fail_now("rvalid_unexpected", "rvalid with no read pending");
                    end else begin
                        e_rd = exp_rd.pop_front();
                        chk("rdata", rdata, e_rd);
                        if (!ack) chk("wait_cnt", wait_cnt, (stall_cnt > 255) ? 255 : stall_cnt);
                    end
                end
                if (ack) begin
                    chk("ack_phase", q, 2'd0);
                    if (exp_acc.size() == 0) begin
                        fail_now("ack_unexpected", "ack with no request pending");
                    end else begin
                        cur = exp_acc.pop_front();
                        chk("ack_bus", {a, rwb, sync, d_out, busy},
                            {cur.addr, ~cur.we, cur.sync, cur.wdata, 1'b1});
                    end
                end
                if (busy) begin
                    chk("bus_hold", {a, rwb, sync, d_out}, {cur.addr, ~cur.we, cur.sync, cur.wdata});
                    exp_oe = cur.we && ((stall_cnt > 0) || (q >= 2'd2));
                    chk("d_oe", d_oe, exp_oe);
                end else begin
                    chk("idle_bus", {a, rwb, sync, d_oe}, {cur.addr, 1'b1, 1'b0, 1'b0});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fclk);
            #3;
        end
    endtask

    // Present one request and hold it until ack; returns periods waited.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic sy, output int lat);
        acc_t t;
        logic idle_start;
        int   q_start;
        t.we = we; t.addr = addr; t.wdata = wd; t.sync = sy;
        if (we) ref_mem[addr] = wd;
        else exp_rd.push_back(ref_mem[addr]);
        exp_acc.push_back(t);
        idle_start = !busy;
        q_start = int'(q);
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_sync = sy;
        lat = 0;
        forever begin
            tick(1);
            lat++;
            if (ack) break;
            if (lat >= 200) begin
                fail_now("ack_timeout", "no ack within 200 fclk");
                break;
            end
        end
        if (idle_start) chk("launch_latency", lat, 4 - q_start);
        req = 1'b0;
        req_we = 1'($urandom); req_addr = 16'($urandom);
        req_wdata = 8'($urandom); req_sync = 1'($urandom);
    endtask

    int lat;
    int n;
    initial begin
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[16'h1234] = 8'hA5;
        dev_mem[16'h1234] = 8'hA5;
        tick(5);
        resb = 1'b1;
        tick(3);

        // Plain read with no waits
        issue(1'b0, 16'h1234, 8'h00, 1'b0, lat);
        chk("t1_ack_addr", {a, rwb}, {16'h1234, 1'b1});
        tick(4);
        chk("t1_rvalid", {rvalid, rdata}, {1'b1, 8'hA5});

        // Write: d_oe only during phi2 of the bus cycle
        issue(1'b1, 16'hFFFE, 8'h3C, 1'b0, lat);
        chk("t2_rwb", {rwb, d_out, d_oe}, {1'b0, 8'h3C, 1'b0});
        tick(2);
        chk("t2_oe_q2", {q, d_oe}, {2'd2, 1'b1});
        tick(1);
        chk("t2_oe_q3", {q, d_oe}, {2'd3, 1'b1});
        tick(1);
        chk("t2_done", {busy, d_oe}, {1'b0, 1'b0});
        chk("t2_mem", dev_mem[16'hFFFE], 8'h3C);

        // Opcode fetch stretched by two wait states
        stall_plan = 2;
        issue(1'b0, 16'h2000, 8'h00, 1'b1, lat);
        stall_plan = 0;
        for (int i = 0; i < 12; i++) begin
            chk("t3_hold", {a, sync, rvalid}, {16'h2000, 1'b1, 1'b0});
            tick(1);
        end
        chk("t3_done", {rvalid, wait_cnt}, {1'b1, 8'd2});

        // Back-to-back read then write
        issue(1'b0, 16'h0010, 8'h00, 1'b0, lat);
        issue(1'b1, 16'h0011, 8'h5A, 1'b0, lat);
        chk("t4_gap", lat, 4);
        chk("t4_ack_rvalid", {ack, rvalid}, {1'b1, 1'b1});
        tick(4);

        // Reset in the middle of a read
        issue(1'b0, 16'h3000, 8'h00, 1'b0, lat);
        tick(2);
        chk("t5_q", q, 2'd2);
        resb = 1'b0;
        exp_rd.delete();
        #1;
        chk("t5_async", {busy, a, rwb}, {1'b0, 16'h0000, 1'b1});
        tick(3);
        resb = 1'b1;
        issue(1'b0, 16'h3001, 8'h00, 1'b0, lat);
        tick(4);

        // Randomized traffic on a small address window
        rand_rdy = 1'b1;
        for (int k = 0; k < 150; k++) begin
            tick($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1)
                issue(1'b1, 16'h0100 + 16'($urandom_range(0, 15)), 8'($urandom), 1'b0, lat);
            else
                issue(1'b0, 16'h0100 + 16'($urandom_range(0, 15)), 8'h00, 1'($urandom), lat);
        end
        n = 0;
        while ((busy || exp_rd.size() != 0) && n < 400) begin
            tick(1);
            n++;
        end
        chk("drain_reads", exp_rd.size(), 0);
        chk("drain_accepts", exp_acc.size(), 0);
        rand_rdy = 1'b0;

        // Phase consistency flag
        chk("phase_clean", phase_err, 1'b0);
        while (q != 2'd1) tick(1);
        p_flip = 1'b1;
        tick(1);
        p_flip = 1'b0;
        tick(1);
        chk("phase_set", phase_err, 1'b1);
        tick(8);
        chk("phase_sticky", phase_err, 1'b1);
        resb = 1'b0;
        tick(1);
        chk("phase_reset", phase_err, 1'b0);
        resb = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bus_cycle_sequencer
